sr_flag_bank_ctrl: RTL
======================

// Module: sr_flag_bank_ctrl
// PURPOSE
//  Arbitrated controller for a bank of NFLAGS SR flip-flop status flags shared by NREQ requesters.
//  - Serialises set/clear requests and issues one-cycle S or R strobes to the external SR flip-flop bank.
//  - Keeps a mirror of the flag state.
//  - Guarantees S and R are never asserted together, so the SR invalid state cannot occur.
//  - Sits between the requesting agents and the sr_flip_flop instances.
// PARAMETERS
//  NREQ    4  number of requesters (2..8)
//  NFLAGS  8  number of SR flags in the bank (1..16)
//  IDXW    3  flag index width; must satisfy 2**IDXW >= NFLAGS
// PORTS
//  clk    in   1          clock, rising edge
//  rst    in   1          reset, asynchronous, active-high
//  req    in   NREQ       request per requester; held high until its ack
//  op     in   NREQ       per-requester operation: 1 = set flag, 0 = clear flag
//  idx    in   NREQ*IDXW  per-requester flag index; requester k uses idx[k*IDXW +: IDXW]
//  ack    out  NREQ       one-hot, one-cycle completion pulse
//  err    out  1          valid with ack: 1 = index out of range, no strobe issued
//  s_out  out  NFLAGS     one-hot, one-cycle set strobe to the SR bank
//  r_out  out  NFLAGS     one-hot, one-cycle reset strobe to the SR bank
//  flags  out  NFLAGS     mirror of the flag state after the strobes
//  busy   out  1          1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (async): FSM=IDLE; rr pointer=0; ack, err, s_out, r_out, flags, busy = 0.
//   A request in flight is dropped without ack; the requester re-requests.
//  FSM IDLE -> STROBE -> ACK -> IDLE; fixed 3 cycles per operation, max 1 op per 3 cycles.
//  IDLE:
//   - No req bit set: stay in IDLE.
//   - Otherwise pick the winner w: the first set req bit at or after the rr pointer, searching
//     upward with wrap-around. Register w, op[w] and idx[w]. Go to STROBE.
//  STROBE (busy=1):
//   - idx < NFLAGS: op=1 -> s_out[idx]=1 and flags[idx]<=1; op=0 -> r_out[idx]=1 and flags[idx]<=0.
//   - idx >= NFLAGS: no strobe; err flag latched. Go to ACK.
//  ACK (busy=1):
//   - ack[w]=1 and err=latched value for exactly this cycle.
//   - rr pointer <= (w+1) mod NREQ. Go to IDLE.
//  Handshake:
//   - Requester holds req/op/idx stable from assertion until ack.
//   - Requester drops req in the cycle after ack.
//   - A req still high in the next IDLE cycle counts as a new request.
//   - Changes to op/idx of a non-granted requester are ignored.
//  Invariant: s_out & r_out == 0 and $onehot0(s_out|r_out) hold every cycle; only STROBE drives them.
//  Redundant op (set an already-set flag, or clear an already-clear flag): strobe and ack issued
//   as normal; flags unchanged.
//  All outputs are registered; s_out/r_out take effect at the SR bank on the next clk edge.
//  Requests arriving while busy are not sampled until the next IDLE cycle; no starvation under
//   round-robin. Worst-case wait is NREQ*3 cycles.
// CONFIGURATION
//  SR_CTRL_FIXED_PRIO_EN:
//   - Defined: fixed priority, the lowest-index set req bit always wins. The rr pointer is not
//     implemented and stays 0. Starvation of high-index requesters is possible and accepted.
//   - Undefined (default): round-robin as described above.
//   - All other behaviour and the port list are identical in both builds.
// TESTING
//  1. Reset with flags=8'hFF preloaded via prior ops, then pulse rst mid-STROBE
//     -> flags=0, no ack, s_out=r_out=0 in the same cycle.
//  2. Single set: req[0]=1, op=1, idx=3 in cycle 0 -> s_out=8'h08 at cycle 1, ack=4'b0001 at
//     cycle 2, flags=8'h08.
//  3. Round-robin: req=4'b1111 held, each requester with a distinct idx -> grant order 0,1,2,3,0,
//     one ack every 3 cycles. With SR_CTRL_FIXED_PRIO_EN defined, requester 0 wins every round.
//  4. Out-of-range: req[2]=1, idx=7 with NFLAGS=6 -> ack[2]=1 with err=1, s_out=r_out=0,
//     flags unchanged.
//  5. Contention on one flag: req[0] set idx 5 and req[1] clear idx 5 asserted in the same cycle
//     -> strobes never overlap; final flags[5]=0 (rr from 0); s_out&r_out==0 every cycle.
//  6. Redundant clear: flags[2]=0, clear idx 2 -> r_out=8'h04 pulse, ack, flags still 0.

Source files
------------

// File: rtl/sr_flag_bank_ctrl_if.sv
// Request/strobe bundle between requesting agents (master) and the SR flag bank controller (slave).
interface sr_flag_bank_ctrl_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [NFLAGS-1:0]    s_out;
    logic [NFLAGS-1:0]    r_out;
    logic [NFLAGS-1:0]    flags;
    logic                 busy;

    modport master (
        output req, op, idx,
        input  ack, err, s_out, r_out, flags, busy
    );

    modport slave (
        input  req, op, idx,
        output ack, err, s_out, r_out, flags, busy
    );
endinterface

// File: rtl/sr_flag_bank_ctrl.sv
// Arbitrated set/clear controller for a bank of SR flags; issues mutually exclusive one-cycle S/R strobes.
// Build option SR_CTRL_FIXED_PRIO_EN: lowest-index requester always wins (no round-robin pointer).
module sr_flag_bank_ctrl #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_flag_bank_ctrl_if.slave   bus
);
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RRW-1:0]    r_win;
    logic [RRW-1:0]    w_win_nxt;
    logic              r_err_lat;
    logic              w_err_lat_nxt;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   w_ack_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [NFLAGS-1:0] r_s_out;
    logic [NFLAGS-1:0] w_s_nxt;
    logic [NFLAGS-1:0] r_r_out;
    logic [NFLAGS-1:0] w_r_nxt;
    logic [NFLAGS-1:0] r_flags;
    logic [NFLAGS-1:0] w_flags_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic [RRW-1:0]    w_rr_base;
    logic [RRW-1:0]    w_grant;
    logic              w_found;
    logic [IDXW-1:0]   w_sel_idx;
    logic              w_sel_op;
    logic              w_in_range;
    logic [NFLAGS-1:0] w_mask;

`ifdef SR_CTRL_FIXED_PRIO_EN
    assign w_rr_base = '0;
`else
    logic [RRW-1:0] r_rr;

    // Round-robin pointer moves just past the requester being acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (r_state == ST_ACK) begin
            r_rr <= (r_win == RRW'(NREQ - 1)) ? RRW'(0) : r_win + RRW'(1);
        end else begin
            r_rr <= r_rr;
        end
    end

    assign w_rr_base = r_rr;
`endif

    // Winner search: first set req at or above the base pointer, wrapping around
    always_comb begin
        int cand;
        w_grant = '0;
        w_found = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(w_rr_base) + k) % NREQ;
            if (!w_found && bus.req[cand]) begin
                w_grant = RRW'(cand);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_sel_idx  = bus.idx[int'(w_grant)*IDXW +: IDXW];
    assign w_sel_op   = bus.op[w_grant];
    assign w_in_range = (32'(w_sel_idx) < NFLAGS);
    assign w_mask     = w_in_range ? (NFLAGS'(1'b1) << w_sel_idx) : '0;

    // Next-state and next-output logic; strobes are prepared on the IDLE->STROBE edge
    always_comb begin
        w_state_nxt   = r_state;
        w_win_nxt     = r_win;
        w_err_lat_nxt = r_err_lat;
        w_ack_nxt     = '0;
        w_err_nxt     = 1'b0;
        w_s_nxt       = '0;
        w_r_nxt       = '0;
        w_flags_nxt   = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ST_STROBE;
                    w_win_nxt     = w_grant;
                    w_err_lat_nxt = !w_in_range;
                    w_s_nxt       = w_sel_op ? w_mask : '0;
                    w_r_nxt       = w_sel_op ? '0 : w_mask;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STROBE: begin
                // The mirror follows the bank, which acts on the strobe at this edge
                w_flags_nxt = (r_flags | r_s_out) & ~r_r_out;
                w_ack_nxt   = NREQ'(1'b1) << r_win;
                w_err_nxt   = r_err_lat;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_win     <= '0;
            r_err_lat <= 1'b0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_s_out   <= '0;
            r_r_out   <= '0;
            r_flags   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_win     <= w_win_nxt;
            r_err_lat <= w_err_lat_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_s_out   <= w_s_nxt;
            r_r_out   <= w_r_nxt;
            r_flags   <= w_flags_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.s_out = r_s_out;
    assign bus.r_out = r_r_out;
    assign bus.flags = r_flags;
    assign bus.busy  = r_busy;
endmodule
